// File: rtl/matriz_leds_varredura_pkg.sv
// Shared types and defaults for the column-scanned LED matrix driver.
// Package name is matriz_pkg; the optional MATRIZ_BRILHO_EN build uses BRILHO_W.
package matriz_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ATIVO = 2'd2
   } estado_t;

   localparam int N_LINHAS_DEF     = 7;
   localparam int N_COLUNAS_DEF    = 5;
   localparam int TICKS_COLUNA_DEF = 1000;
   localparam int TICKS_BLANK_DEF  = 2;
   localparam int BRILHO_W         = 4;

   // larger of two dwell lengths, sizes the shared dwell counter
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/matriz_leds_varredura_if.sv
// Frame/scan bus of the LED matrix driver.
// master = frame source (drives enable/load/mapa_in), slave = scanner.
// With MATRIZ_BRILHO_EN defined the bus also carries brilho.
interface matriz_leds_varredura_if #(
   parameter int N_LINHAS  = matriz_pkg::N_LINHAS_DEF,
   parameter int N_COLUNAS = matriz_pkg::N_COLUNAS_DEF
);
   localparam int IW = $clog2(N_COLUNAS);

   logic                          enable;
   logic [N_LINHAS*N_COLUNAS-1:0] mapa_in;
   logic                          load;
   logic                          pendente;
   logic [N_LINHAS-1:0]           linhas;
   logic [N_COLUNAS-1:0]          colunas;
   logic [IW-1:0]                 coluna_idx;
   logic                          frame_fim;
`ifdef MATRIZ_BRILHO_EN
   logic [matriz_pkg::BRILHO_W-1:0] brilho;

   modport master (output enable, mapa_in, load, brilho,
                   input  pendente, linhas, colunas, coluna_idx, frame_fim);
   modport slave  (input  enable, mapa_in, load, brilho,
                   output pendente, linhas, colunas, coluna_idx, frame_fim);
`else
   modport master (output enable, mapa_in, load,
                   input  pendente, linhas, colunas, coluna_idx, frame_fim);
   modport slave  (input  enable, mapa_in, load,
                   output pendente, linhas, colunas, coluna_idx, frame_fim);
`endif
endinterface

// File: rtl/matriz_leds_varredura_demux_coluna.sv
// Column index -> one-hot column select; all zero when not valid.
module demux_coluna #(
   parameter int N_COLUNAS = matriz_pkg::N_COLUNAS_DEF,
   parameter int IW        = $clog2(N_COLUNAS)
) (
   input  logic [IW-1:0]        idx,
   input  logic                 valid,
   output logic [N_COLUNAS-1:0] colunas
);
   // one compare per column; out-of-range indices light nothing
   for (genvar c = 0; c < N_COLUNAS; c++) begin : g_col
      assign colunas[c] = valid && (idx == IW'(c));
   end
endmodule

// File: rtl/matriz_leds_varredura.sv
// Column-scanning LED matrix driver with double-buffered frames.
// Each column: TICKS_BLANK dark cycles, then TICKS_COLUNA lit cycles.
// A frame loaded while scanning waits in the shadow buffer and is swapped in
// only at the end of a full scan, so one frame never mixes two buffers.
// Optional: MATRIZ_BRILHO_EN adds PWM dimming of the rows via bus.brilho.
module matriz_leds_varredura
   import matriz_pkg::*;
#(
   parameter int N_LINHAS     = N_LINHAS_DEF,
   parameter int N_COLUNAS    = N_COLUNAS_DEF,
   parameter int TICKS_COLUNA = TICKS_COLUNA_DEF,
   parameter int TICKS_BLANK  = TICKS_BLANK_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   matriz_leds_varredura_if.slave    bus
);
   localparam int IW = $clog2(N_COLUNAS);
   localparam int CW = $clog2(max2(TICKS_COLUNA, TICKS_BLANK) + 1);

   typedef logic [N_COLUNAS-1:0][N_LINHAS-1:0] mapa_t;

   estado_t             estado, estado_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic [IW-1:0]       idx, idx_nx;
   logic                fim_frame;
   mapa_t               ativo, sombra;
   logic                pend;
   logic [N_LINHAS-1:0] col_sel;
   logic                acende;

   // state, dwell counter and column index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= IDLE;
         cnt    <= '0;
         idx    <= '0;
      end else begin
         estado <= estado_nx;
         cnt    <= cnt_nx;
         idx    <= idx_nx;
      end
   end

   // next state: dwell timing, column advance, frame end; enable low wins
   always_comb begin
      estado_nx = estado;
      cnt_nx    = cnt;
      idx_nx    = idx;
      fim_frame = 1'b0;
      case (estado)
         IDLE: begin
            cnt_nx = '0;
            idx_nx = '0;
            if (bus.enable) estado_nx = BLANK;
         end
         BLANK: begin
            if (cnt == CW'(TICKS_BLANK - 1)) begin
               estado_nx = ATIVO;
               cnt_nx    = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         ATIVO: begin
            if (cnt == CW'(TICKS_COLUNA - 1)) begin
               estado_nx = BLANK;
               cnt_nx    = '0;
               if (idx == IW'(N_COLUNAS - 1)) begin
                  idx_nx    = '0;
                  fim_frame = 1'b1;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: estado_nx = IDLE;
      endcase
      if (!bus.enable) begin
         estado_nx = IDLE;
         cnt_nx    = '0;
         idx_nx    = '0;
         fim_frame = 1'b0;
      end
   end

   // frame buffers: direct write when idle, shadow capture while scanning,
   // shadow->active swap only at frame end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ativo  <= '0;
         sombra <= '0;
         pend   <= 1'b0;
      end else if (estado == IDLE) begin
         if (bus.load) ativo <= bus.mapa_in;
      end else if (fim_frame && pend) begin
         ativo <= sombra;
         pend  <= 1'b0;
      end else if (bus.load && !pend) begin
         sombra <= bus.mapa_in;
         pend   <= 1'b1;
      end
   end

   // slice of the active buffer for the current column
   always_comb begin
      col_sel = '0;
      for (int c = 0; c < N_COLUNAS; c++)
         if (idx == IW'(c)) col_sel = ativo[c];
   end

`ifdef MATRIZ_BRILHO_EN
   logic [BRILHO_W-1:0] fase;

   // PWM phase: held at 0 outside ATIVO so each column starts at phase 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               fase <= '0;
      else if (estado != ATIVO) fase <= '0;
      else                      fase <= fase + 1'b1;
   end

   assign acende = (estado == ATIVO) && (fase < bus.brilho);
`else
   assign acende = (estado == ATIVO);
`endif

   // row drive: row r shows slice bit (N_LINHAS-1-r)
   always_comb begin
      bus.linhas = '0;
      for (int r = 0; r < N_LINHAS; r++)
         bus.linhas[r] = acende && col_sel[N_LINHAS-1-r];
   end

   demux_coluna #(.N_COLUNAS(N_COLUNAS), .IW(IW)) u_demux (
      .idx     (idx),
      .valid   (estado == ATIVO),
      .colunas (bus.colunas)
   );

   assign bus.pendente   = pend;
   assign bus.coluna_idx = idx;
   assign bus.frame_fim  = fim_frame;

endmodule

// File: tb/tb_matriz_leds_varredura.sv
// Directed bench for matriz_leds_varredura: 7x5 matrix, 4 lit + 1 dark cycle.
module tb_matriz_leds_varredura;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   pexp  = 1'b0;

   logic [34:0]      map_a, map_b, map_c;
   logic [4:0][6:0]  ea, eb;

   matriz_leds_varredura_if #(.N_LINHAS(7), .N_COLUNAS(5)) bus ();

   matriz_leds_varredura #(
      .N_LINHAS(7), .N_COLUNAS(5), .TICKS_COLUNA(4), .TICKS_BLANK(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one full scan from a BLANK sample of column 0; loads at ATIVO cycle l1 (map_b)
   // and l2 (map_c), cycle = col*4 + k, -1 = none
   task automatic run_frame(input logic [4:0][6:0] e, input int l1, input int l2);
      bit np, last;
      int cyc;
      for (int c = 0; c < 5; c++) begin
         chk("blk_col", 32'(bus.colunas), 32'd0);
         chk("blk_lin", 32'(bus.linhas), 32'd0);
         chk("blk_idx", 32'(bus.coluna_idx), 32'(c));
         chk("blk_fim", 32'(bus.frame_fim), 32'd0);
         chk("blk_pend", 32'(bus.pendente), 32'(pexp));
         step();
         for (int k = 0; k < 4; k++) begin
            cyc  = c * 4 + k;
            last = (c == 4) && (k == 3);
            chk("col", 32'(bus.colunas), 32'(1 << c));
            chk("lin", 32'(bus.linhas), 32'(e[c]));
            chk("idx", 32'(bus.coluna_idx), 32'(c));
            chk("fim", 32'(bus.frame_fim), 32'(last));
            chk("pend", 32'(bus.pendente), 32'(pexp));
            np = 1'b0;
            if (cyc == l1) begin
               bus.load = 1'b1; bus.mapa_in = map_b; np = !pexp;
            end else if (cyc == l2) begin
               bus.load = 1'b1; bus.mapa_in = map_c; np = !pexp;
            end
            step();
            bus.load = 1'b0;
            if (last)    pexp = 1'b0;
            else if (np) pexp = 1'b1;
         end
      end
   endtask

`ifdef MATRIZ_BRILHO_EN
   initial bus.brilho = 4'hF;
`endif

   initial begin
      map_a = {7'b1110000, 7'b0101010, 7'b0000001, 7'b1000000, 7'b0000100};
      map_b = {7'b0000000, 7'b1000001, 7'b0011000, 7'b0000011, 7'b1111111};
      map_c = {5{7'b0000001}};
      ea[0] = 7'b0010000; ea[1] = 7'b0000001; ea[2] = 7'b1000000;
      ea[3] = 7'b0101010; ea[4] = 7'b0000111;
      eb[0] = 7'b1111111; eb[1] = 7'b1100000; eb[2] = 7'b0001100;
      eb[3] = 7'b1000001; eb[4] = 7'b0000000;

      rst_n = 1'b0; bus.enable = 1'b0; bus.load = 1'b0; bus.mapa_in = '0;
      #1;
      chk("rst_lin", 32'(bus.linhas), 32'd0);
      chk("rst_col", 32'(bus.colunas), 32'd0);
      chk("rst_idx", 32'(bus.coluna_idx), 32'd0);
      chk("rst_pend", 32'(bus.pendente), 32'd0);
      chk("rst_fim", 32'(bus.frame_fim), 32'd0);
      step(); step();
      rst_n = 1'b1;

      // load straight into the active buffer from IDLE, start scanning
      bus.enable = 1'b1; bus.load = 1'b1; bus.mapa_in = map_a;
      step();
      bus.load = 1'b0;
      chk("idle_pend", 32'(bus.pendente), 32'd0);
      run_frame(ea, -1, -1);
      // mid-frame load then a second load that must be ignored
      run_frame(ea, 5, 13);
      run_frame(eb, -1, -1);

      // drop enable during column 2
      repeat (12) step();
      chk("c2_col", 32'(bus.colunas), 32'b00100);
      bus.enable = 1'b0;
      step();
      chk("dis_lin", 32'(bus.linhas), 32'd0);
      chk("dis_col", 32'(bus.colunas), 32'd0);
      chk("dis_idx", 32'(bus.coluna_idx), 32'd0);
      step();
      bus.enable = 1'b1;
      step();
      chk("ren_blk_col", 32'(bus.colunas), 32'd0);
      chk("ren_idx", 32'(bus.coluna_idx), 32'd0);
      step();
      chk("ren_col", 32'(bus.colunas), 32'b00001);
      chk("ren_lin", 32'(bus.linhas), 32'(eb[0]));

      // asynchronous reset between edges while lit
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_lin", 32'(bus.linhas), 32'd0);
      chk("arst_col", 32'(bus.colunas), 32'd0);
      chk("arst_idx", 32'(bus.coluna_idx), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_blk", 32'(bus.colunas), 32'd0);
      step();
      chk("post_col", 32'(bus.colunas), 32'b00001);
      chk("post_lin", 32'(bus.linhas), 32'd0);
      chk("post_pend", 32'(bus.pendente), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/matriz_leds_varredura.md
MATRIZ_LEDS_VARREDURA -- requirements
Module: matriz_leds_varredura

Interface
REQ-001 Parameter N_LINHAS, default 7, number of row lines.
REQ-002 Parameter N_COLUNAS, default 5, number of column lines; SHALL be ≥2.
REQ-003 Parameter TICKS_COLUNA, default 1000, clock cycles each column is lit; SHALL be ≥1.
REQ-004 Parameter TICKS_BLANK, default 2, all-dark clock cycles before each column; SHALL be ≥1.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active-low.
REQ-007 enable  in  1  scan run; low forces IDLE.
REQ-008 mapa_in  in  N_LINHAS*N_COLUNAS  new frame; column c occupies bits [c*N_LINHAS +: N_LINHAS].
REQ-009 load  in  1  frame load request, sampled each cycle.
REQ-010 pendente  out  1  shadow frame waiting for swap.
REQ-011 linhas  out  N_LINHAS  row drive, active-high.
REQ-012 colunas  out  N_COLUNAS  column select, one-hot active-high or all zero.
REQ-013 coluna_idx  out  $clog2(N_COLUNAS)  index of the current column.
REQ-014 frame_fim  out  1  one-cycle pulse at end of each full scan.

Function
REQ-015 FSM states IDLE, BLANK, ATIVO; a dwell counter counts cycles within BLANK and ATIVO.
REQ-016 IDLE: linhas=0, colunas=0, coluna_idx=0; enable=1 -> BLANK next cycle.
REQ-017 BLANK: linhas=0, colunas=0; after TICKS_BLANK cycles -> ATIVO.
REQ-018 ATIVO: colunas[coluna_idx]=1; linhas[r] = bit (N_LINHAS-1-r) of the active column slice; after TICKS_COLUNA cycles -> BLANK.
REQ-019 ATIVO exit with coluna_idx<N_COLUNAS-1: coluna_idx increments.
REQ-020 ATIVO exit with coluna_idx=N_COLUNAS-1: coluna_idx wraps to 0, frame_fim=1 for that cycle, pending swap applies.
REQ-021 enable=0 in any state -> IDLE next cycle; dwell counter and coluna_idx clear; active and shadow buffers are retained.
REQ-022 load=1 with pendente=0 outside IDLE: mapa_in captured into shadow buffer, pendente=1 next cycle.
REQ-023 load=1 with pendente=1: ignored; shadow buffer is not overwritten.
REQ-024 load=1 in IDLE: mapa_in written directly to active buffer; pendente unchanged.
REQ-025 Swap at frame end: active<=shadow, pendente<=0; a load in the same cycle is ignored per REQ-023.
REQ-026 Frame data SHALL never change mid-frame; all columns of one frame come from one buffer.

Reset
REQ-027 rst_n=0: state=IDLE, dwell counter=0, coluna_idx=0, pendente=0, frame_fim=0, linhas=0, colunas=0, both buffers=0.
REQ-028 Reset mid-scan takes effect immediately, without waiting for a clock edge; the first scan after release starts at column 0 with BLANK.

Configuration
REQ-029 Macro MATRIZ_BRILHO_EN defined: add input brilho[3:0]; a 4-bit phase counter clears on ATIVO entry and increments each ATIVO cycle; linhas are driven per REQ-018 only while phase<brilho, otherwise 0; brilho=0 gives a dark display; brilho is sampled each cycle.
REQ-030 Macro undefined: no brilho port; linhas are driven for the full ATIVO period.

Structure
REQ-031 Shared package matriz_pkg: FSM state enum, default parameter constants, brightness width constant (4).
REQ-032 One sub-module, demux_coluna: coluna_idx plus a valid signal in, one-hot colunas out; valid=0 drives all zeros.

Verification
All scenarios use N_LINHAS=7, N_COLUNAS=5, TICKS_COLUNA=4, TICKS_BLANK=1.
REQ-033 Reset, then enable=1, load mapa in IDLE with column0=7'b0000100 -> column0 ATIVO shows colunas=5'b00001, linhas=7'b0010000 for exactly 4 cycles, preceded by 1 dark cycle.
REQ-034 Full scan -> colunas sequence 00001,00010,00100,01000,10000, each separated by 1 blank cycle; frame_fim pulses once per 25 cycles; coluna_idx wraps to 0.
REQ-035 load mid-frame with a new pattern -> pendente=1, current frame unchanged, new pattern visible from next column 0, pendente=0 after swap; a second load while pendente=1 leaves the shadow buffer unchanged.
REQ-036 enable dropped during column 2 -> next cycle linhas=0, colunas=0, coluna_idx=0; re-enable restarts at column 0.
REQ-037 rst_n asserted mid-ATIVO between clock edges -> outputs zero immediately, buffers=0.
REQ-038 With MATRIZ_BRILHO_EN, brilho=2 -> linhas lit on 2 of 4 ATIVO cycles per column; brilho=0 -> linhas always 0.
